mips_multicycle_ctrl: RTL and testbench

Control FSM for the multicycle variant of the MIPS datapath. It decodes the latched instruction fields and produces the ALU operation code that the ALU consumes. It takes the ALU's zero flag back to resolve branches, and it drives every datapath strobe and mux select. It sits between the instruction register, the memory port, the register file and the 3-bit-func ALU. It stalls on a memory ready handshake.

---
 rtl/mips_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALU function, mux selects and datapath strobes.
module mips_multicycle_ctrl #(
    parameter int unsigned ALU_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic [ALU_W-1:0] alu_func,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_zero,
    output logic [1:0]       pc_source,
    output logic             pc_en,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal
);

    localparam int unsigned OP_W = 6;

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_NOR = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_LUI = ALU_W'(6);

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPE_EX, S_IMM_EX, S_ALU_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] funct_q;
    logic [ALU_W-1:0] r_alu, i_alu;
    logic             r_ok, i_ext;

    // State register; instruction fields captured while IR is valid in DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
        end
    end

    // R-type funct decode
    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (funct_q)
            6'h20, 6'h21: r_alu = ALU_ADD;
            6'h22, 6'h23: r_alu = ALU_SUB;
            6'h24:        r_alu = ALU_AND;
            6'h25:        r_alu = ALU_OR;
            6'h27:        r_alu = ALU_NOR;
            6'h2A, 6'h2B: r_alu = ALU_SLT;
            default:      r_ok  = 1'b0;
        endcase
    end

    // Immediate-op decode
    always_comb begin
        i_alu = ALU_ADD;
        i_ext = 1'b0;
        case (op_q)
            OP_SLTI: i_alu = ALU_SLT;
            OP_ANDI: begin i_alu = ALU_AND; i_ext = 1'b1; end
            OP_ORI:  begin i_alu = ALU_OR;  i_ext = 1'b1; end
            OP_LUI:  i_alu = ALU_LUI;
            default: i_alu = ALU_ADD;
        endcase
    end

    // Next state and outputs; everything forced low while reset is held
    always_comb begin
        state_d    = state_q;
        alu_func   = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        ext_zero   = 1'b0;
        pc_source  = 2'd0;
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_RTYPE:                 state_d = S_RTYPE_EX;
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:           state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_SLTI,
                    OP_ANDI, OP_ORI, OP_LUI:  state_d = S_IMM_EX;
                    default:                  state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_func  = r_alu;
                state_d   = r_ok ? S_ALU_WB : S_TRAP;
            end
            S_IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_func  = i_alu;
                ext_zero  = i_ext;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                alu_src_a = 1'b1;
                if (op_q == OP_RTYPE) begin
                    reg_dst  = 1'b1;
                    alu_func = r_alu;
                end else begin
                    alu_src_b = 2'd2;
                    alu_func  = i_alu;
                    ext_zero  = i_ext;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_func  = ALU_SUB;
                pc_source = 2'd1;
                pc_en     = (op_q == OP_BEQ) ? zero_flag : ~zero_flag;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'd2;
                pc_en     = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        if (!rst_n) begin
            alu_func   = '0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'd0;
            ext_zero   = 1'b0;
            pc_source  = 2'd0;
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            iord       = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle expected output vectors
// are queued as stimulus is applied and compared at the following negedge.
module tb_mips_multicycle_ctrl;

    localparam int unsigned VW = 18;
    typedef logic [VW-1:0] vec_t;

    typedef struct {
        vec_t  exp;
        vec_t  care;
        string tag;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero_flag, mem_ready;
    logic [2:0] alu_func;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic       pc_en, ir_write, mem_read, mem_write, iord;
    logic       reg_write, reg_dst, mem_to_reg, illegal;

    int   total = 0;
    int   bad   = 0;
    sb_t  sb_q[$];
    vec_t care_next = '1;

    localparam logic [5:0] JOP = 6'h3F;
    localparam logic [5:0] JFN = 6'h18;
    localparam vec_t NO_ALU = {3'b000, 15'h7FFF};

    mips_multicycle_ctrl #(.ALU_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero_flag(zero_flag), .mem_ready(mem_ready), .alu_func(alu_func),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
        .pc_source(pc_source), .pc_en(pc_en), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] alu, input logic a, input logic [1:0] b,
                                input logic ext, input logic [1:0] pcs, input logic pe,
                                input logic irw, input logic mr, input logic mw, input logic io,
                                input logic rw, input logic rd, input logic m2r, input logic ill);
        return {alu, a, b, ext, pcs, pe, irw, mr, mw, io, rw, rd, m2r, ill};
    endfunction

    function automatic vec_t e_rst();                   return '0; endfunction
    function automatic vec_t e_fetch(input logic r);    return mk(0,0,1,0,0, r,r,1,0,0, 0,0,0,0); endfunction
    function automatic vec_t e_decode();                return mk(0,0,3,0,0, 0,0,0,0,0, 0,0,0,0); endfunction
    function automatic vec_t e_memadr();                return mk(0,1,2,0,0, 0,0,0,0,0, 0,0,0,0); endfunction
    function automatic vec_t e_memrd();                 return mk(0,0,0,0,0, 0,0,1,0,1, 0,0,0,0); endfunction
    function automatic vec_t e_memwb();                 return mk(0,0,0,0,0, 0,0,0,0,0, 1,0,1,0); endfunction
    function automatic vec_t e_memwr();                 return mk(0,0,0,0,0, 0,0,0,1,1, 0,0,0,0); endfunction
    function automatic vec_t e_rex(input logic [2:0] f); return mk(f,1,0,0,0, 0,0,0,0,0, 0,0,0,0); endfunction
    function automatic vec_t e_rwb(input logic [2:0] f); return mk(f,1,0,0,0, 0,0,0,0,0, 1,1,0,0); endfunction
    function automatic vec_t e_iex(input logic [2:0] f, input logic x); return mk(f,1,2,x,0, 0,0,0,0,0, 0,0,0,0); endfunction
    function automatic vec_t e_iwb(input logic [2:0] f, input logic x); return mk(f,1,2,x,0, 0,0,0,0,0, 1,0,0,0); endfunction
    function automatic vec_t e_branch(input logic pe);  return mk(1,1,0,0,1, pe,0,0,0,0, 0,0,0,0); endfunction
    function automatic vec_t e_jump();                  return mk(0,0,0,0,2, 1,0,0,0,0, 0,0,0,0); endfunction
    function automatic vec_t e_trap();                  return mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,1); endfunction

    function automatic vec_t observed();
        return {alu_func, alu_src_a, alu_src_b, ext_zero, pc_source, pc_en, ir_write,
                mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, illegal};
    endfunction

    task automatic check_one();
        sb_t  s;
        vec_t obs;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty observed=none expected=entry");
            return;
        end
        s   = sb_q.pop_front();
        obs = observed();
        total++;
        assert ((obs & s.care) === (s.exp & s.care)) else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h care=%05h", s.tag, obs, s.exp, s.care);
        end
    endtask

    // One clock: drive inputs, queue expectation, compare at negedge, advance
    task automatic cyc(input string tag, input logic r, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input logic rdy, input vec_t exp);
        sb_t s;
        rst_n     = r;
        opcode    = op;
        funct     = fn;
        zero_flag = z;
        mem_ready = rdy;
        s.exp  = exp;
        s.care = care_next;
        s.tag  = tag;
        sb_q.push_back(s);
        care_next = '1;
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rz();
        return 1'($urandom_range(0, 1));
    endfunction

    initial begin
        rst_n = 1'b0; opcode = JOP; funct = JFN; zero_flag = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset_outputs_zero", 0, JOP, JFN, 1, 1, e_rst());

        // R-type add
        cyc("add_fetch",  1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("add_decode", 1, 6'h00, 6'h20, rz(), 1, e_decode());
        cyc("add_ex",     1, JOP, JFN, rz(), 1, e_rex(3'd0));
        cyc("add_wb",     1, JOP, JFN, rz(), 1, e_rwb(3'd0));

        // lw with two wait cycles in MEMRD
        cyc("lw_fetch",   1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("lw_decode",  1, 6'h23, JFN, rz(), 1, e_decode());
        cyc("lw_memadr",  1, JOP, JFN, rz(), 1, e_memadr());
        cyc("lw_memrd_w1", 1, JOP, JFN, rz(), 0, e_memrd());
        cyc("lw_memrd_w2", 1, JOP, JFN, rz(), 0, e_memrd());
        cyc("lw_memrd_go", 1, JOP, JFN, rz(), 1, e_memrd());
        cyc("lw_memwb",   1, JOP, JFN, rz(), 1, e_memwb());

        // Branches: beq/bne with both zero_flag values
        cyc("beq1_fetch",  1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("beq1_decode", 1, 6'h04, JFN, rz(), 1, e_decode());
        cyc("beq1_branch", 1, JOP, JFN, 1, 1, e_branch(1));
        cyc("beq0_fetch",  1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("beq0_decode", 1, 6'h04, JFN, rz(), 1, e_decode());
        cyc("beq0_branch", 1, JOP, JFN, 0, 1, e_branch(0));
        cyc("bne1_fetch",  1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("bne1_decode", 1, 6'h05, JFN, rz(), 1, e_decode());
        cyc("bne1_branch", 1, JOP, JFN, 1, 1, e_branch(0));
        cyc("bne0_fetch",  1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("bne0_decode", 1, 6'h05, JFN, rz(), 1, e_decode());
        cyc("bne0_branch", 1, JOP, JFN, 0, 1, e_branch(1));

        // Immediate ops
        cyc("ori_fetch",  1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("ori_decode", 1, 6'h0D, JFN, rz(), 1, e_decode());
        cyc("ori_ex",     1, JOP, JFN, rz(), 1, e_iex(3'd3, 1));
        cyc("ori_wb",     1, JOP, JFN, rz(), 1, e_iwb(3'd3, 1));
        cyc("lui_fetch",  1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("lui_decode", 1, 6'h0F, JFN, rz(), 1, e_decode());
        cyc("lui_ex",     1, JOP, JFN, rz(), 1, e_iex(3'd6, 0));
        cyc("lui_wb",     1, JOP, JFN, rz(), 1, e_iwb(3'd6, 0));
        cyc("slti_fetch", 1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("slti_decode", 1, 6'h0A, JFN, rz(), 1, e_decode());
        cyc("slti_ex",    1, JOP, JFN, rz(), 1, e_iex(3'd5, 0));
        cyc("slti_wb",    1, JOP, JFN, rz(), 1, e_iwb(3'd5, 0));

        // More R-type functs
        cyc("sub_fetch",  1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("sub_decode", 1, 6'h00, 6'h22, rz(), 1, e_decode());
        cyc("sub_ex",     1, JOP, JFN, rz(), 1, e_rex(3'd1));
        cyc("sub_wb",     1, JOP, JFN, rz(), 1, e_rwb(3'd1));
        cyc("nor_fetch",  1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("nor_decode", 1, 6'h00, 6'h27, rz(), 1, e_decode());
        cyc("nor_ex",     1, JOP, JFN, rz(), 1, e_rex(3'd4));
        cyc("nor_wb",     1, JOP, JFN, rz(), 1, e_rwb(3'd4));

        // Jump
        cyc("j_fetch",  1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("j_decode", 1, 6'h02, JFN, rz(), 1, e_decode());
        cyc("j_jump",   1, JOP, JFN, rz(), 1, e_jump());

        // sw with a fetch wait and a write wait
        cyc("sw_fetch_w",  1, JOP, JFN, rz(), 0, e_fetch(0));
        cyc("sw_fetch",    1, JOP, JFN, rz(), 1, e_fetch(1));
        cyc("sw_decode",   1, 6'h2B, JFN, rz(), 1, e_decode());
        cyc("sw_memadr",   1, JOP, JFN, rz(), 1, e_memadr());
        cyc("sw_memwr_w",  1, JOP, JFN, rz(), 0, e_memwr());
        cyc("sw_memwr_go", 1, JOP, JFN, rz(), 1, e_memwr());
        cyc("after_sw_fetch", 1, JOP, JFN, rz(), 1, e_fetch(1));

        // Reset in the middle of MEMWR
        cyc("swr_decode",  1, 6'h2B, JFN, rz(), 1, e_decode());
        cyc("swr_memadr",  1, JOP, JFN, rz(), 1, e_memadr());
        cyc("swr_memwr_w", 1, JOP, JFN, rz(), 0, e_memwr());
        cyc("swr_reset",   0, JOP, JFN, rz(), 1, e_rst());
        cyc("swr_restart_fetch", 1, JOP, JFN, rz(), 0, e_fetch(0));
        cyc("swr_fetch",   1, JOP, JFN, rz(), 1, e_fetch(1));

        // Illegal opcode traps and sticks until reset
        cyc("trapop_decode", 1, 6'h3F, JFN, rz(), 1, e_decode());
        cyc("trapop_trap1",  1, 6'h00, 6'h20, rz(), 1, e_trap());
        cyc("trapop_trap2",  1, 6'h23, 6'h20, rz(), 0, e_trap());
        cyc("trapop_trap3",  1, 6'h02, 6'h20, rz(), 1, e_trap());
        cyc("trapop_reset",  0, JOP, JFN, rz(), 1, e_rst());
        cyc("trapop_after_fetch", 1, JOP, JFN, rz(), 1, e_fetch(1));

        // Illegal R-type funct traps from RTYPE_EX
        cyc("trapfn_decode", 1, 6'h00, 6'h18, rz(), 1, e_decode());
        care_next = NO_ALU;
        cyc("trapfn_ex",     1, JOP, JFN, rz(), 1, e_rex(3'd0));
        cyc("trapfn_trap1",  1, JOP, JFN, rz(), 1, e_trap());
        cyc("trapfn_trap2",  1, JOP, JFN, rz(), 1, e_trap());
        cyc("trapfn_reset",  0, JOP, JFN, rz(), 1, e_rst());
        cyc("trapfn_after_fetch", 1, JOP, JFN, rz(), 1, e_fetch(1));

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
